// File: rtl/store_commit_buffer_if.sv
// Store commit buffer bus: ROB commit side, D-cache write side, status and load lookup.
// Load-forwarding signals exist only when STORE_BUF_FWD_EN is defined.
interface store_commit_buffer_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  commit_valid;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_data;
    logic                  commit_stall;

    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic                  mem_req_ready;

    logic                  empty;
    logic [CNT_W-1:0]      count;

`ifdef STORE_BUF_FWD_EN
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_hit;
    logic [DATA_WIDTH-1:0] ld_data;

    modport master (
        output commit_valid, commit_addr, commit_data, mem_req_ready, ld_addr,
        input  commit_stall, mem_req_valid, mem_req_addr, mem_req_data, empty, count,
               ld_hit, ld_data
    );
    modport slave (
        input  commit_valid, commit_addr, commit_data, mem_req_ready, ld_addr,
        output commit_stall, mem_req_valid, mem_req_addr, mem_req_data, empty, count,
               ld_hit, ld_data
    );
`else
    modport master (
        output commit_valid, commit_addr, commit_data, mem_req_ready,
        input  commit_stall, mem_req_valid, mem_req_addr, mem_req_data, empty, count
    );
    modport slave (
        input  commit_valid, commit_addr, commit_data, mem_req_ready,
        output commit_stall, mem_req_valid, mem_req_addr, mem_req_data, empty, count
    );
`endif
endinterface

// File: rtl/store_commit_buffer.sv
// In-order FIFO of committed stores draining to the D-cache write port.
// Define STORE_BUF_FWD_EN to add store-to-load forwarding (ld_addr/ld_hit/ld_data).
module store_commit_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    store_commit_buffer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic             full_c, empty_c, enq_c, deq_c;
    logic [PTR_W-1:0] count_c;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign count_c = wr_ptr_q - rd_ptr_q;
    assign enq_c   = bus.commit_valid && !full_c;
    assign deq_c   = !empty_c && bus.mem_req_ready;

    assign bus.commit_stall  = full_c;
    assign bus.mem_req_valid = !empty_c;
    assign bus.mem_req_addr  = addr_q[rd_ptr_q[IDX_W-1:0]];
    assign bus.mem_req_data  = data_q[rd_ptr_q[IDX_W-1:0]];
    assign bus.empty         = empty_c;
    assign bus.count         = count_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (deq_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (enq_c) begin
            addr_q[wr_ptr_q[IDX_W-1:0]] <= bus.commit_addr;
            data_q[wr_ptr_q[IDX_W-1:0]] <= bus.commit_data;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic                  ld_hit_c;
    logic [DATA_WIDTH-1:0] ld_data_c;
    logic [PTR_W-1:0]      fwd_idx;

    // Scan oldest to youngest so the last match wins; a same-cycle enqueue is youngest.
    always_comb begin
        ld_hit_c  = 1'b0;
        ld_data_c = '0;
        fwd_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((PTR_W'(i) < count_c) &&
                (addr_q[fwd_idx[IDX_W-1:0]][ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2])) begin
                ld_hit_c  = 1'b1;
                ld_data_c = data_q[fwd_idx[IDX_W-1:0]];
            end
        end
        if (enq_c && (bus.commit_addr[ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2])) begin
            ld_hit_c  = 1'b1;
            ld_data_c = bus.commit_data;
        end
    end

    assign bus.ld_hit  = ld_hit_c;
    assign bus.ld_data = ld_data_c;
`endif

endmodule

// File: doc/store_commit_buffer.md
STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entry count (power of two, >=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning store address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning store data width.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: commit_valid  in  1  ROB head is a committing store; commit_addr  in  ADDR_WIDTH  store address; commit_data  in  DATA_WIDTH  store data.
REQ-006 SHALL have port commit_stall  out  1  buffer cannot accept; fed to ROB store stall.
REQ-007 SHALL have ports: mem_req_valid  out  1; mem_req_addr  out  ADDR_WIDTH; mem_req_data  out  DATA_WIDTH; mem_req_ready  in  1; together the D-cache write handshake.
REQ-008 SHALL have ports: empty  out  1  no pending stores; count  out  log2(DEPTH)+1  occupancy.
REQ-009 SHALL have ports, when STORE_BUF_FWD_EN is defined: ld_addr  in  ADDR_WIDTH  load lookup; ld_hit  out  1; ld_data  out  DATA_WIDTH.

Function
REQ-010 SHALL implement a circular FIFO with rd/wr pointers of log2(DEPTH)+1 bits; MSB is the wrap bit.
REQ-011 SHALL define empty as pointers equal, full as low bits equal and wrap bits different.
REQ-012 SHALL drive commit_stall = full, combinationally; no same-cycle bypass when full, even if a dequeue also occurs.
REQ-013 SHALL enqueue on posedge when commit_valid & !full; wr_ptr increments by 1, wrapping modulo 2*DEPTH.
REQ-014 SHALL ignore commit_valid while full; the ROB holds its head store.
REQ-015 SHALL drive mem_req_valid = !empty; mem_req_addr/data from the head entry, combinationally.
REQ-016 SHALL dequeue on posedge when mem_req_valid & mem_req_ready; rd_ptr increments by 1.
REQ-017 SHALL keep mem_req_valid, addr and data stable until accepted.
REQ-018 SHALL allow simultaneous enqueue and dequeue in one cycle; count unchanged.
REQ-019 SHALL present a newly enqueued store on mem_req no earlier than the cycle after enqueue; minimum latency 1 cycle.
REQ-020 SHALL drain strictly in commit order; no merging or reordering.
REQ-021 SHALL NOT discard entries on pipeline flush; entries are architecturally committed.
REQ-022 SHALL drive count = wr_ptr - rd_ptr, modulo 2*DEPTH.

Reset
REQ-023 SHALL on rst_n low at posedge clear both pointers and all entry valid state.
REQ-024 SHALL after reset output empty=1, count=0, commit_stall=0, mem_req_valid=0, ld_hit=0.
REQ-025 SHALL drop a pending unaccepted mem request on reset mid-operation; the next request appears only after a new enqueue.

Configuration
REQ-026 SHALL, with STORE_BUF_FWD_EN defined, compare ld_addr[ADDR_WIDTH-1:2] against every valid entry's address[ADDR_WIDTH-1:2] combinationally.
REQ-027 SHALL, on multiple matches, return in ld_data the data of the youngest matching entry, nearest wr_ptr.
REQ-028 SHALL include a same-cycle enqueue in the lookup, so a commit_data word matching ld_addr forwards immediately.
REQ-029 SHALL, without STORE_BUF_FWD_EN, omit ld_* ports and comparison logic entirely.

Verification
REQ-030 Reset, then commit 0x100/0xAA with ready=1 -> next cycle mem_req_valid=1, addr 0x100, data 0xAA; accepted; empty=1 after.
REQ-031 ready=0, commit 4 stores 0x10..0x1C -> count=4, commit_stall=1; 5th commit ignored; raise ready -> 0x10,0x14,0x18,0x1C drain in order.
REQ-032 Full buffer with ready=1 and commit_valid=1 -> stall stays 1 that cycle; count 4->3; next cycle enqueue accepted.
REQ-033 Fill/drain 9 stores through DEPTH=4 -> pointer wrap correct, all data in order, count back to 0.
REQ-034 FWD_EN: stores 0x200/0x11 then 0x200/0x22 held (ready=0); ld_addr=0x202 -> ld_hit=1, ld_data=0x22; ld_addr=0x300 -> ld_hit=0.
REQ-035 Assert rst_n=0 with 3 entries and mem_req_valid=1 -> next cycle empty=1, mem_req_valid=0, count=0.
